conv_psum_acc: RTL and testbench

- Downstream of the 5-tap MAC processing element in the LeNet-5 conv datapath.
- Accepts one signed 32-bit row partial sum per handshake and accumulates ROWS row sums into one output pixel. For a 5x5 kernel, ROWS = 5.
- Post-processes each pixel: bias add, rounding arithmetic right shift, optional ReLU, saturation to int8.
- Buffers results in a small FIFO and presents them on a valid/ready output to the feature-map writer.

---
 rtl/conv_psum_acc.sv | 173 +++++++++++++++++
 tb/tb_conv_psum_acc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_psum_acc.sv
// conv_psum_acc: accumulates ROWS signed row partial sums into one conv output
// pixel, then adds bias, applies a rounding arithmetic right shift, optional
// ReLU and int8 saturation, and queues the pixel in a small valid/ready FIFO.
module conv_psum_acc #(
   parameter int PSUM_W     = 32,
   parameter int ACC_W      = 40,
   parameter int OUT_W      = 8,
   parameter int ROWS       = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [31:0]       cfg_bias,
   input  logic [4:0]        cfg_shift,
   input  logic              cfg_relu,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PSUM_W-1:0] in_psum,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              busy,
   output logic              sat_flag
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (OUT_W - 1)));

   // Configuration registers
   logic signed [31:0]       bias_q;
   logic [4:0]               shift_q;
   logic                     relu_q;

   // Stage 1 state
   logic [CNT_W-1:0]         row_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  post_sum;
   logic                     post_valid;

   // Output FIFO state
   logic [OUT_W-1:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W:0]           fifo_count;

   logic                     accept;
   logic                     pop;
   logic signed [ACC_W-1:0]  psum_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  rounded;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [ACC_W-1:0]  relu_v;
   logic [OUT_W-1:0]         q_out;
   logic                     clamped;

   assign psum_ext = {{(ACC_W - PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
   assign bias_ext = {{(ACC_W - 32){bias_q[31]}}, bias_q};

   // Space is reserved for the pixel in stage 2 so that stage 2 never stalls.
   assign in_ready  = (fifo_count + (PTR_W + 1)'(post_valid)) < (PTR_W + 1)'(FIFO_DEPTH);
   assign accept    = in_valid && in_ready;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign busy      = (row_cnt != '0) || post_valid || out_valid;

   // Requantize the completed pixel sum: round-half-up shift, ReLU, saturate.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rounded = post_sum;
      clamped = 1'b0;
      q_out   = '0;
      if (shift_q != 5'd0) begin
         rounded = post_sum + (ACC_W'(1) << (shift_q - 5'd1));
      end
      shifted = rounded >>> shift_q;
      relu_v  = (relu_q && shifted < 0) ? '0 : shifted;
      if (relu_v > MAX_V) begin
         q_out   = MAX_V[OUT_W-1:0];
         clamped = 1'b1;
      end else if (relu_v < MIN_V) begin
         q_out   = MIN_V[OUT_W-1:0];
         clamped = 1'b1;
      end else begin
         q_out   = relu_v[OUT_W-1:0];
      end
   end

   // Config writes are only taken while the datapath is idle.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         bias_q  <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else if (cfg_we && !busy) begin
         bias_q  <= cfg_bias;
         shift_q <= cfg_shift;
         relu_q  <= cfg_relu;
      end
   end

   // Stage 1: row accumulation; the final row adds bias and hands off to stage 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt    <= '0;
         acc        <= '0;
         post_sum   <= '0;
         post_valid <= 1'b0;
      end else if (flush) begin
         row_cnt    <= '0;
         acc        <= '0;
         post_valid <= 1'b0;
      end else begin
         post_valid <= 1'b0;
         if (accept) begin
            if (row_cnt == LAST_ROW) begin
               post_sum   <= acc + psum_ext + bias_ext;
               post_valid <= 1'b1;
               acc        <= '0;
               row_cnt    <= '0;
            end else begin
               acc     <= acc + psum_ext;
               row_cnt <= row_cnt + CNT_W'(1);
            end
         end
      end
   end

   // FIFO storage; the contents are qualified by fifo_count.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; out_data is masked while empty so stale words never escape.
      if (post_valid && !flush) begin
         mem[wr_ptr] <= q_out;
      end
   end

   // FIFO pointers and occupancy; push comes from stage 2, pop from the consumer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (post_valid) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
         case ({post_valid, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Sticky saturation indicator, set whenever a written pixel was clamped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if (post_valid && clamped && !flush) begin
         sat_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_psum_acc.sv
// Directed bench for conv_psum_acc: basic pixel, rounding/bias, saturation and
// ReLU, backpressure, flush, config guard and asynchronous reset mid-window.
module tb_conv_psum_acc;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_we;
   logic [31:0]        cfg_bias;
   logic [4:0]         cfg_shift;
   logic               cfg_relu;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_psum;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_data;
   logic               busy;
   logic               sat_flag;

   int vectors    = 0;
   int miscompares = 0;

   conv_psum_acc dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_bias  (cfg_bias),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_psum   (in_psum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int v);
      in_valid = 1'b1;
      in_psum  = v;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) break;
         @(negedge clk);
      end
      check("send_ready", int'(in_ready), 1);
      if (in_ready) begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic window(input int a, input int b, input int c, input int d, input int e);
      send(a); send(b); send(c); send(d); send(e);
   endtask

   // Waits for a pixel, checks it, and lets it pop (out_ready must be 1).
   task automatic wait_pixel(input string tag, input int expected);
      for (int i = 0; i < 50; i++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      check({tag, "_valid"}, int'(out_valid), 1);
      check(tag, int'($signed(out_data)), expected);
      @(negedge clk);
   endtask

   task automatic configure(input int bias, input int shift, input bit relu);
      cfg_we    = 1'b1;
      cfg_bias  = bias;
      cfg_shift = 5'(shift);
      cfg_relu  = relu;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_bias  = '0;
      cfg_shift = '0;
      cfg_relu  = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_psum   = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_sat", int'(sat_flag), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);

      // 1. basic pixel, latency 2 cycles after final accept
      configure(0, 0, 1'b0);
      window(1, 2, 3, 4, 5);
      check("t1_lat1", int'(out_valid), 0);
      @(negedge clk);
      check("t1_lat2", int'(out_valid), 1);
      check("t1_data", int'($signed(out_data)), 15);
      @(negedge clk);
      check("t1_single", int'(out_valid), 0);
      check("t1_sat", int'(sat_flag), 0);

      // 2. rounding and bias
      configure(-5, 1, 1'b0);
      window(1, 2, 3, 4, 5);
      wait_pixel("t2_bias", 5);
      configure(0, 2, 1'b0);
      window(-7, 0, 0, 0, 0);
      wait_pixel("t2_round", -2);
      check("t2_sat", int'(sat_flag), 0);

      // 3. saturation and ReLU
      configure(0, 0, 1'b0);
      window(100, 100, 100, 0, 0);
      wait_pixel("t3_pos_sat", 127);
      check("t3_sat_flag", int'(sat_flag), 1);
      window(-300, 0, 0, 0, 0);
      wait_pixel("t3_neg_sat", -128);
      configure(0, 0, 1'b1);
      window(-300, 0, 0, 0, 0);
      wait_pixel("t3_relu", 0);
      check("t3_sat_sticky", int'(sat_flag), 1);

      // 4. backpressure: four pixels fill the FIFO, the fifth window stalls
      configure(0, 0, 1'b0);
      out_ready = 1'b0;
      window(1, 0, 0, 0, 0);
      window(2, 0, 0, 0, 0);
      window(3, 0, 0, 0, 0);
      window(4, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_full_ready", int'(in_ready), 0);
      check("t4_head", int'($signed(out_data)), 1);
      in_valid = 1'b1;
      in_psum  = 5;
      for (int i = 0; i < 3; i++) begin
         check("t4_held", int'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t4_ready_back", int'(in_ready), 1);
      check("t4_head2", int'($signed(out_data)), 2);
      window(5, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_full_again", int'(in_ready), 0);
      out_ready = 1'b1;
      wait_pixel("t4_pix2", 2);
      wait_pixel("t4_pix3", 3);
      wait_pixel("t4_pix4", 4);
      wait_pixel("t4_pix5", 5);
      check("t4_drained", int'(out_valid), 0);
      check("t4_ready_end", int'(in_ready), 1);

      // 5. flush discards the partial window; config ignored while busy
      send(7); send(8); send(9);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("t5_flush_busy", int'(busy), 0);
      window(1, 2, 3, 4, 5);
      wait_pixel("t5_flush_pix", 15);
      check("t5_single", int'(out_valid), 0);
      send(1); send(2);
      check("t5_busy", int'(busy), 1);
      configure(100, 0, 1'b0);
      send(3); send(4); send(5);
      wait_pixel("t5_cfg_guard", 15);

      // 6. async reset with two psums accepted and one pixel buffered
      out_ready = 1'b0;
      window(1, 2, 3, 4, 5);
      send(6); send(7);
      check("t6_pre_valid", int'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_valid", int'(out_valid), 0);
      check("t6_rst_data", int'(out_data), 0);
      check("t6_rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      window(1, 2, 3, 4, 5);
      wait_pixel("t6_pix", 15);
      check("t6_single", int'(out_valid), 0);
      check("t6_sat", int'(sat_flag), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
